ob_cmd_deframer: RTL and testbench



---
 rtl/ob_pkg.sv | 36 +++
 rtl/ob_cmd_deframer.sv | 127 ++++++++++++
 tb/tb_ob_cmd_deframer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
`default_nettype none
// ============================================================================
// ob_pkg : shared order-book types, command layout and deframer constants
// Rev 1.0
// ============================================================================
package ob_pkg;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_MODIFY = 2'd2,
    OP_NOP    = 2'd3
  } op_t;

  typedef struct packed {
    op_t         op;
    logic        side;
    logic [15:0] order_id;
    logic [15:0] price;
    logic [11:0] qty;
  } cmd_t;

  localparam int CMD_W     = $bits(cmd_t);
  localparam int CMD_BYTES = (CMD_W + 7) / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    CSUM = 2'd2,
    EMIT = 2'd3
  } deframer_state_t;

endpackage
`default_nettype wire

// File: rtl/ob_cmd_deframer.sv
`default_nettype none
// ============================================================================
// ob_cmd_deframer : hunts for frame sync, assembles and XOR-checks one cmd_t
//                   per frame, and issues it as a single-cycle strobe
// Rev 1.0
// ============================================================================
module ob_cmd_deframer #(
  parameter int         CMD_BYTES = ob_pkg::CMD_BYTES,
  parameter logic [7:0] SYNC_BYTE = ob_pkg::FRAME_SYNC,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [7:0]       in_data,
  output logic             in_rdy,
  output logic             cmd_vld_r,
  output ob_pkg::cmd_t     cmd_r,
  input  logic             cmd_full_r,
  output logic [CNT_W-1:0] frame_cnt_r,
  output logic [CNT_W-1:0] err_cnt_r
);

  import ob_pkg::*;

  localparam int               CW       = $bits(ob_pkg::cmd_t);
  localparam int               IDX_W    = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  deframer_state_t  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [CW-1:0]    shreg_q, shreg_d;
  logic             cmd_vld_q, cmd_vld_d;
  ob_pkg::cmd_t     cmd_q, cmd_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             acc;

  assign in_rdy = ~rst & (state_q != EMIT);
  assign acc    = in_vld & in_rdy;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    shreg_d     = shreg_q;
    cmd_vld_d   = 1'b0;
    cmd_d       = cmd_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc && (in_data == SYNC_BYTE)) begin
          idx_d   = '0;
          csum_d  = 8'h00;
          state_d = BODY;
        end
      end
      BODY: begin
        if (acc) begin
          // Register holds only cmd_t bits, so pad bits of the first byte fall off the top
          shreg_d = (shreg_q << 8) | CW'(in_data);
          csum_d  = csum_q ^ in_data;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (in_data == csum_q) begin
            state_d = EMIT;
          end else begin
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      EMIT: begin
        // Waiting on cmd_vld_q too keeps strobes apart so cmd_full_r reflects the last push
        if (!cmd_full_r && !cmd_vld_q) begin
          cmd_d     = ob_pkg::cmd_t'(shreg_q);
          cmd_vld_d = 1'b1;
          if (frame_cnt_q != CNT_MAX) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      shreg_q     <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      shreg_q     <= shreg_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_q       <= cmd_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_vld_r   = cmd_vld_q;
  assign cmd_r       = cmd_q;
  assign frame_cnt_r = frame_cnt_q;
  assign err_cnt_r   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ob_cmd_deframer.sv
`default_nettype none
// ============================================================================
// tb_ob_cmd_deframer : scoreboard bench for the command deframer
// Rev 1.0
// ============================================================================
module tb_ob_cmd_deframer;

  localparam int NB    = ob_pkg::CMD_BYTES;
  localparam int CW    = $bits(ob_pkg::cmd_t);
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_rdy;
  logic             cmd_vld_r;
  ob_pkg::cmd_t     cmd_r;
  logic             cmd_full_r = 1'b0;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  typedef struct {
    logic [CW-1:0] cmd;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_mon;
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            last_vld_cyc = -10;
  int            exp_frames = 0;
  int            exp_errs = 0;
  logic [CW-1:0] last_cmd = '0;

  ob_cmd_deframer #(
    .CMD_BYTES (NB),
    .SYNC_BYTE (8'hA5),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .cmd_vld_r   (cmd_vld_r),
    .cmd_r       (cmd_r),
    .cmd_full_r  (cmd_full_r),
    .frame_cnt_r (frame_cnt_r),
    .err_cnt_r   (err_cnt_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pop one expected command per strobe; cyc here is the strobe's cycle index
  always @(negedge clk) begin
    if (!rst && cmd_vld_r) begin
      chk("pulse_gap", 64'((cyc - last_vld_cyc) > 1), 64'd1);
      last_vld_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("cmd", 64'(cmd_r), 64'(e_mon.cmd));
        chk("latency", 64'(cyc), 64'(e_mon.due));
        last_cmd = e_mon.cmd;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_vld  = 1'b1;
    in_data = b;
    #1;
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [NB*8-1:0] body, input logic [7:0] flip, input bit push);
    logic [7:0] x;
    exp_t       e;
    x = 8'h00;
    send_byte(8'hA5);
    for (int i = NB - 1; i >= 0; i--) begin
      send_byte(body[i*8 +: 8]);
      x = x ^ body[i*8 +: 8];
    end
    send_byte(x ^ flip);
    if (flip != 8'h00) begin
      exp_errs++;
    end else begin
      exp_frames++;
      if (push) begin
        e.cmd = body[CW-1:0];
        e.due = acc_cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NB*8-1:0] rand_body();
    logic [NB*8-1:0] b;
    for (int i = 0; i < NB; i++) b[i*8 +: 8] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  initial begin
    logic [NB*8-1:0] body;
    exp_t            e;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", 64'(cmd_vld_r), 64'd0);
    chk("rst_cmd", 64'(cmd_r), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt_r), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt_r), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_in_rdy", 64'(in_rdy), 64'd1);
    @(negedge clk);

    // Good frame, body 01..NB
    for (int i = 0; i < NB; i++) body[(NB-1-i)*8 +: 8] = 8'(i + 1);
    send_frame(body, 8'h00, 1'b1);
    idle(4);
    chk("good_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));

    // Garbage ahead of sync
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(rand_body(), 8'h00, 1'b1);
    idle(4);
    chk("garbage_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));
    chk("garbage_err_cnt", 64'(err_cnt_r), 64'd0);

    // Bad checksum, then a good frame
    send_frame(rand_body(), 8'h01, 1'b1);
    idle(4);
    chk("bad_err_cnt", 64'(err_cnt_r), 64'd1);
    chk("bad_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));
    send_frame(rand_body(), 8'h00, 1'b1);
    idle(4);
    chk("after_bad_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));

    // Backpressure with the next sync byte already waiting
    cmd_full_r = 1'b1;
    body = rand_body();
    send_frame(body, 8'h00, 1'b0);
    in_vld  = 1'b1;
    in_data = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      @(negedge clk);
    end
    cmd_full_r = 1'b0;
    e.cmd = body[CW-1:0];
    e.due = cyc + 1;
    sb.push_back(e);
    send_frame(rand_body(), 8'h00, 1'b1);
    idle(4);
    chk("bp_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));

    // Three frames back to back
    for (int f = 0; f < 3; f++) send_frame(rand_body(), 8'h00, 1'b1);
    idle(5);
    chk("b2b_frame_cnt", 64'(frame_cnt_r), 64'(exp_frames));

    // Reset mid-body drops the partial frame and clears counters
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    exp_frames = 0;
    exp_errs   = 0;
    chk("rst_mid_frame_cnt", 64'(frame_cnt_r), 64'd0);
    chk("rst_mid_err_cnt", 64'(err_cnt_r), 64'd0);
    rst    = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    send_frame(rand_body(), 8'h00, 1'b1);
    idle(5);
    chk("post_rst_frame_cnt", 64'(frame_cnt_r), 64'd1);
    chk("post_rst_err_cnt", 64'(err_cnt_r), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("cmd_hold", 64'(cmd_r), 64'(last_cmd));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
